// File: rtl/ex_issue_ctrl_if.sv
// Handshake and data bundle between ID, the EX-stage sequencer, the ALU and MEM/WB.
// The master side is the surrounding pipeline; the slave side is ex_issue_ctrl.
interface ex_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [5:0]       id_alu_op;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_rd_we;
    logic [31:0]      id_rs1_data;
    logic [31:0]      id_rs2_data;
    logic [31:0]      id_imm;
    logic [31:0]      id_pc;
    logic             flush;

    logic [5:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;
    logic [31:0]      alu_result;

    logic             exm_valid;
    logic             exm_ready;
    logic [5:0]       exm_alu_op;
    logic [4:0]       exm_rd;
    logic             exm_rd_we;
    logic [31:0]      exm_result;
    logic [31:0]      exm_store_data;

    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;

    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rd_we,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
               alu_result, exm_ready, wb_we, wb_rd, wb_data,
        input  id_ready, alu_op, alu_a, alu_b, alu_imm, alu_pc,
               exm_valid, exm_alu_op, exm_rd, exm_rd_we, exm_result,
               exm_store_data, stall_cnt
    );

    modport slave (
        input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rd_we,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
               alu_result, exm_ready, wb_we, wb_rd, wb_data,
        output id_ready, alu_op, alu_a, alu_b, alu_imm, alu_pc,
               exm_valid, exm_alu_op, exm_rd, exm_rd_we, exm_result,
               exm_store_data, stall_cnt
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// EX-stage sequencer: operand forwarding, load-use stall, ALU drive and the EX/MEM register
// with valid/ready handshakes toward ID and MEM.
module ex_issue_ctrl #(
    parameter int CNT_W  = 16,
    parameter bit FWD_EN = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    ex_issue_ctrl_if.slave bus
);
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_AND = 6'd7;
    localparam logic [5:0] OP_LW  = 6'd8;
    localparam logic [5:0] OP_SW  = 6'd10;
    localparam logic [5:0] OP_JAL = 6'd14;

    logic             exm_valid_q;
    logic [5:0]       exm_alu_op_q;
    logic [4:0]       exm_rd_q;
    logic             exm_rd_we_q;
    logic [31:0]      exm_result_q;
    logic [31:0]      exm_store_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic        use_rs1;
    logic        use_rs2;
    logic        op_legal;
    logic        load_block;
    logic        hazard;
    logic        ready;
    logic        capture;
    logic        stall;
    logic [31:0] src_a;
    logic [31:0] src_b;

    // A load in EX/MEM has no data yet, so it only forwards once it reaches MEM/WB.
    function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] rf_data);
        logic [31:0] value;
        value = rf_data;
        if (src == 5'd0) begin
            value = 32'd0;
        end else if (FWD_EN) begin
            if (exm_valid_q && exm_rd_we_q && exm_rd_q == src && exm_alu_op_q != OP_LW) begin
                value = exm_result_q;
            end else if (bus.wb_we && bus.wb_rd == src) begin
                value = bus.wb_data;
            end
        end
        return value;
    endfunction

    always_comb begin
        use_rs1  = bus.id_alu_op != OP_JAL;
        use_rs2  = (bus.id_alu_op >= OP_ADD && bus.id_alu_op <= OP_AND) || bus.id_alu_op == OP_SW;
        op_legal = (bus.id_alu_op >= OP_ADD && bus.id_alu_op <= OP_SW) || bus.id_alu_op == OP_JAL;

        src_a = use_rs1 ? forward(bus.id_rs1, bus.id_rs1_data) : bus.id_rs1_data;
        src_b = use_rs2 ? forward(bus.id_rs2, bus.id_rs2_data) : bus.id_rs2_data;

        // Without forwarding, any pending write to a source must retire before issue.
        load_block = exm_valid_q && exm_rd_we_q && (!FWD_EN || exm_alu_op_q == OP_LW);
        hazard     = load_block &&
                     ((use_rs1 && bus.id_rs1 != 5'd0 && bus.id_rs1 == exm_rd_q) ||
                      (use_rs2 && bus.id_rs2 != 5'd0 && bus.id_rs2 == exm_rd_q));

        ready   = (!exm_valid_q || bus.exm_ready) && !hazard;
        capture = bus.id_valid && ready && !bus.flush;
        stall   = bus.id_valid && !ready && !bus.flush;
    end

    assign bus.id_ready       = ready;
    assign bus.alu_op         = bus.id_alu_op;
    assign bus.alu_a          = src_a;
    assign bus.alu_b          = src_b;
    assign bus.alu_imm        = bus.id_imm;
    assign bus.alu_pc         = bus.id_pc;
    assign bus.exm_valid      = exm_valid_q;
    assign bus.exm_alu_op     = exm_alu_op_q;
    assign bus.exm_rd         = exm_rd_q;
    assign bus.exm_rd_we      = exm_rd_we_q;
    assign bus.exm_result     = exm_result_q;
    assign bus.exm_store_data = exm_store_q;
    assign bus.stall_cnt      = stall_cnt_q;

    // A capture may coincide with MEM draining the previous op, giving one op per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q  <= 1'b0;
            exm_alu_op_q <= 6'd0;
            exm_rd_q     <= 5'd0;
            exm_rd_we_q  <= 1'b0;
            exm_result_q <= 32'd0;
            exm_store_q  <= 32'd0;
        end else if (capture) begin
            exm_valid_q  <= 1'b1;
            exm_alu_op_q <= bus.id_alu_op;
            exm_rd_q     <= bus.id_rd;
            exm_rd_we_q  <= bus.id_rd_we && (bus.id_rd != 5'd0) && op_legal;
            exm_result_q <= op_legal ? bus.alu_result : 32'd0;
            exm_store_q  <= src_b;
        end else if (bus.exm_ready) begin
            exm_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural pipeline model.
module tb_ex_issue_ctrl;
    typedef struct {
        bit          valid;
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        bit          we;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        bit          flush;
        bit          ready;
    } stim_t;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    ex_issue_ctrl_if #(.CNT_W(16)) bus ();

    ex_issue_ctrl #(.CNT_W(16), .FWD_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference EX/MEM slot, MEM/WB writeback and stall counter.
    bit          m_valid;
    logic [5:0]  m_op;
    logic [4:0]  m_rd;
    bit          m_we;
    logic [31:0] m_result;
    logic [31:0] m_store;
    int unsigned m_stall;
    bit          pend_we;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    logic [31:0] load_value;
    logic        seen_ready;
    logic [31:0] seen_alu_a;

    logic [5:0] op_list [12] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                 6'd8, 6'd9, 6'd10, 6'd14, 6'h3F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm,
                                           input logic [31:0] pc);
        case (op)
            6'd1:            return a + b;
            6'd2:            return a - b;
            6'd3:            return a << b[4:0];
            6'd4:            return a ^ b;
            6'd5:            return a >> b[4:0];
            6'd6:            return a | b;
            6'd7:            return a & b;
            6'd8, 6'd9, 6'd10: return a + imm;
            6'd14:           return pc + 32'd4;
            default:         return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_imm, bus.alu_pc);

    function automatic bit reads_rs1(input logic [5:0] op);
        return op != 6'd14;
    endfunction

    function automatic bit reads_rs2(input logic [5:0] op);
        return op inside {[6'd1:6'd7], 6'd10};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {[6'd1:6'd10], 6'd14};
    endfunction

    // Value of register s as the ALU must see it: youngest non-load producer first, then WB, then RF.
    function automatic logic [31:0] m_src(input logic [4:0] s, input logic [31:0] rf);
        if (s == 5'd0) return 32'd0;
        if (m_valid && m_we && m_rd == s && m_op != 6'd8) return m_result;
        if (bus.wb_we && bus.wb_rd == s) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return reads_rs1(bus.id_alu_op) ? m_src(bus.id_rs1, bus.id_rs1_data) : bus.id_rs1_data;
    endfunction

    function automatic logic [31:0] exp_b();
        return reads_rs2(bus.id_alu_op) ? m_src(bus.id_rs2, bus.id_rs2_data) : bus.id_rs2_data;
    endfunction

    function automatic bit exp_ready();
        bit hz;
        hz = m_valid && m_op == 6'd8 && m_we &&
             ((reads_rs1(bus.id_alu_op) && bus.id_rs1 != 5'd0 && bus.id_rs1 == m_rd) ||
              (reads_rs2(bus.id_alu_op) && bus.id_rs2 != 5'd0 && bus.id_rs2 == m_rd));
        return (!m_valid || bus.exm_ready) && !hz;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_op      = 6'd0;
        m_rd      = 5'd0;
        m_we      = 0;
        m_result  = 32'd0;
        m_store   = 32'd0;
        m_stall   = 0;
        pend_we   = 0;
        pend_rd   = 5'd0;
        pend_data = 32'd0;
    endtask

    task automatic model_update();
        bit          rdy;
        logic [31:0] a;
        logic [31:0] b;
        rdy = exp_ready();
        a   = exp_a();
        b   = exp_b();
        if (bus.id_valid && !rdy && !bus.flush && m_stall < 32'hFFFF) m_stall++;
        pend_we   = m_valid && bus.exm_ready && m_we;
        pend_rd   = m_rd;
        pend_data = (m_op == 6'd8) ? load_value : m_result;
        if (bus.id_valid && rdy && !bus.flush) begin
            m_valid  = 1;
            m_op     = bus.id_alu_op;
            m_rd     = bus.id_rd;
            m_we     = bus.id_rd_we && bus.id_rd != 5'd0 && is_legal(bus.id_alu_op);
            m_result = is_legal(bus.id_alu_op) ? alu_fn(bus.id_alu_op, a, b, bus.id_imm, bus.id_pc) : 32'd0;
            m_store  = b;
        end else if (bus.exm_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_output();
        cmp("id_ready", {31'd0, bus.id_ready}, {31'd0, exp_ready()});
        cmp("alu_op", {26'd0, bus.alu_op}, {26'd0, bus.id_alu_op});
        cmp("alu_a", bus.alu_a, exp_a());
        cmp("alu_b", bus.alu_b, exp_b());
        cmp("alu_imm", bus.alu_imm, bus.id_imm);
        cmp("alu_pc", bus.alu_pc, bus.id_pc);
        cmp("exm_valid", {31'd0, bus.exm_valid}, {31'd0, m_valid});
        cmp("stall_cnt", {16'd0, bus.stall_cnt}, m_stall);
        if (m_valid) begin
            cmp("exm_alu_op", {26'd0, bus.exm_alu_op}, {26'd0, m_op});
            cmp("exm_rd", {27'd0, bus.exm_rd}, {27'd0, m_rd});
            cmp("exm_rd_we", {31'd0, bus.exm_rd_we}, {31'd0, m_we});
            cmp("exm_result", bus.exm_result, m_result);
            cmp("exm_store_data", bus.exm_store_data, m_store);
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        @(negedge clk);
        bus.id_valid    = s.valid;
        bus.id_alu_op   = s.op;
        bus.id_rs1      = s.rs1;
        bus.id_rs2      = s.rs2;
        bus.id_rd       = s.rd;
        bus.id_rd_we    = s.we;
        bus.id_rs1_data = s.d1;
        bus.id_rs2_data = s.d2;
        bus.id_imm      = s.imm;
        bus.id_pc       = s.pc;
        bus.flush       = s.flush;
        bus.exm_ready   = s.ready;
        bus.wb_we       = pend_we;
        bus.wb_rd       = pend_rd;
        bus.wb_data     = pend_data;
        #1;
        seen_ready = bus.id_ready;
        seen_alu_a = bus.alu_a;
        check_output();
        @(posedge clk);
        #1;
        model_update();
    endtask

    function automatic stim_t mk(input bit valid, input logic [5:0] op, input logic [4:0] rs1,
                                 input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                                 input logic [4:0] rd, input logic [31:0] imm, input bit flush,
                                 input bit ready);
        stim_t s;
        s.valid = valid; s.op = op; s.rs1 = rs1; s.d1 = d1; s.rs2 = rs2; s.d2 = d2;
        s.rd = rd; s.we = 1; s.imm = imm; s.pc = 32'h0000_1000; s.flush = flush; s.ready = ready;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid = ($urandom_range(0, 99) < 75);
        s.op    = op_list[$urandom_range(0, 11)];
        s.rs1   = 5'($urandom_range(0, 7));
        s.rs2   = 5'($urandom_range(0, 7));
        s.rd    = 5'($urandom_range(0, 7));
        s.we    = ($urandom_range(0, 9) < 8);
        s.d1    = $urandom;
        s.d2    = $urandom;
        s.imm   = $urandom;
        s.pc    = $urandom;
        s.flush = ($urandom_range(0, 9) == 0);
        s.ready = ($urandom_range(0, 9) < 7);
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.id_valid = 0; bus.flush = 0; bus.exm_ready = 0;
        bus.id_alu_op = 6'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
        bus.id_rd_we = 0; bus.id_rs1_data = 32'd0; bus.id_rs2_data = 32'd0;
        bus.id_imm = 32'd0; bus.id_pc = 32'd0;
        bus.wb_we = 0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset exm_valid", {31'd0, bus.exm_valid}, 32'd0);
        cmp("reset exm_result", bus.exm_result, 32'd0);
        cmp("reset exm_rd", {27'd0, bus.exm_rd}, 32'd0);
        cmp("reset exm_alu_op", {26'd0, bus.exm_alu_op}, 32'd0);
        cmp("reset exm_store_data", bus.exm_store_data, 32'd0);
        cmp("reset exm_rd_we", {31'd0, bus.exm_rd_we}, 32'd0);
        cmp("reset stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        cmp("reset id_ready", {31'd0, bus.id_ready}, 32'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        load_value   = 32'h10;
        do_reset();

        $display("[TB] forwarding from EX/MEM");
        apply_stimulus(mk(1, 6'd1, 5'd2, 32'd5, 5'd3, 32'd3, 5'd1, 32'd0, 0, 1));
        cmp("t1 add result", bus.exm_result, 32'd8);
        apply_stimulus(mk(1, 6'd2, 5'd1, 32'd0, 5'd5, 32'd2, 5'd6, 32'd0, 0, 1));
        cmp("t1 sub result", bus.exm_result, 32'd6);
        cmp("t1 no stall", {16'd0, bus.stall_cnt}, 32'd0);

        $display("[TB] load-use stall");
        apply_stimulus(mk(1, 6'd8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 32'h100, 0, 1));
        apply_stimulus(mk(1, 6'd9, 5'd4, 32'd0, 5'd0, 32'd0, 5'd7, 32'd1, 0, 1));
        cmp("t2 stalled ready", {31'd0, seen_ready}, 32'd0);
        cmp("t2 stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        apply_stimulus(mk(1, 6'd9, 5'd4, 32'd0, 5'd0, 32'd0, 5'd7, 32'd1, 0, 1));
        cmp("t2 accepted ready", {31'd0, seen_ready}, 32'd1);
        cmp("t2 addi result", bus.exm_result, 32'h11);

        $display("[TB] MEM back-pressure");
        repeat (3) apply_stimulus(mk(1, 6'd9, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'h22, 0, 0));
        cmp("t3 held ready", {31'd0, seen_ready}, 32'd0);
        cmp("t3 held result", bus.exm_result, 32'h11);
        cmp("t3 stall_cnt", {16'd0, bus.stall_cnt}, 32'd4);
        apply_stimulus(mk(1, 6'd9, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'h22, 0, 1));
        cmp("t3 release result", bus.exm_result, 32'h22);

        $display("[TB] flush");
        apply_stimulus(mk(0, 6'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 1));
        apply_stimulus(mk(1, 6'd9, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'd5, 1, 1));
        cmp("t4 flush exm_valid", {31'd0, bus.exm_valid}, 32'd0);
        cmp("t4 flush stall_cnt", {16'd0, bus.stall_cnt}, 32'd4);

        $display("[TB] x0 and illegal opcode");
        apply_stimulus(mk(1, 6'd1, 5'd2, 32'd4, 5'd3, 32'd5, 5'd0, 32'd0, 0, 1));
        cmp("t5 add rd0 result", bus.exm_result, 32'd9);
        cmp("t5 add rd0 we", {31'd0, bus.exm_rd_we}, 32'd0);
        apply_stimulus(mk(1, 6'd7, 5'd0, 32'hFF, 5'd3, 32'hF0, 5'd0, 32'd0, 0, 1));
        cmp("t5 and alu_a", seen_alu_a, 32'd0);
        cmp("t5 and we", {31'd0, bus.exm_rd_we}, 32'd0);
        apply_stimulus(mk(1, 6'h3F, 5'd1, 32'd7, 5'd2, 32'd8, 5'd3, 32'd0, 0, 1));
        cmp("t5 illegal we", {31'd0, bus.exm_rd_we}, 32'd0);
        cmp("t5 illegal result", bus.exm_result, 32'd0);

        $display("[TB] asynchronous reset");
        apply_stimulus(mk(1, 6'd9, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'd1, 0, 0));
        cmp("t6 pre stall_cnt", {16'd0, bus.stall_cnt}, 32'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("t6 async exm_valid", {31'd0, bus.exm_valid}, 32'd0);
        cmp("t6 async stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        do_reset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            load_value = $urandom;
            apply_stimulus(rand_stim());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
